// File: rtl/matmul_seq_if.sv
// Job/result handshake bundle for the sequential NxN matrix multiplier.
// The producer/consumer side uses the master modport, the multiplier the slave.
interface matmul_seq_if #(
  parameter int N         = 2,
  parameter int DataWidth = 8,
  parameter int AccWidth  = 2 * DataWidth + $clog2(N)
);
  logic                       in_valid_i;
  logic                       in_ready_o;
  logic                       signed_i;
  logic                       accumulate_i;
  logic [N*N*DataWidth-1:0]   operand_a_i;
  logic [N*N*DataWidth-1:0]   operand_b_i;
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [N*N*AccWidth-1:0]    result_o;

  modport master (
    output in_valid_i, signed_i, accumulate_i, operand_a_i, operand_b_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o
  );

  modport slave (
    input  in_valid_i, signed_i, accumulate_i, operand_a_i, operand_b_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o
  );
endinterface

// File: rtl/matmul_seq.sv
// Sequential NxN integer matrix multiplier: one C element per cycle using
// N parallel multipliers and an adder tree, optional signed elements and
// accumulation into the held result. Sums wrap modulo 2^AccWidth.
module matmul_seq #(
  parameter int N         = 2,
  parameter int DataWidth = 8,
  parameter int AccWidth  = 2 * DataWidth + $clog2(N)
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  matmul_seq_if.slave bus
);

  localparam int RowW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]               state_q;
  logic [RowW-1:0]          row_q;
  logic [RowW-1:0]          col_q;
  logic [N*N*DataWidth-1:0] a_q;
  logic [N*N*DataWidth-1:0] b_q;
  logic                     sgn_q;
  logic                     acc_q;
  logic [N*N*AccWidth-1:0]  res_q;

  logic [DataWidth-1:0]         a_e;
  logic [DataWidth-1:0]         b_e;
  logic signed [DataWidth:0]    ax;
  logic signed [DataWidth:0]    bx;
  logic signed [2*DataWidth+1:0] prod_full;
  logic [2*DataWidth-1:0]       prod;
  logic [AccWidth-1:0]          prod_ext;
  logic [AccWidth-1:0]          dot;
  logic [AccWidth-1:0]          cur;
  logic                         last;

  // Dot product of row (row_q) of A with column (col_q) of B.
  always_comb begin
    // NOTE: every variable gets a default before any conditional or loop
    // assignment, so no path can leave one unassigned and infer a latch.
    a_e       = '0;
    b_e       = '0;
    ax        = '0;
    bx        = '0;
    prod_full = '0;
    prod      = '0;
    prod_ext  = '0;
    dot       = '0;
    for (int k = 0; k < N; k++) begin
      a_e = a_q[(int'(row_q) * N + k) * DataWidth +: DataWidth];
      b_e = b_q[(k * N + int'(col_q)) * DataWidth +: DataWidth];
      // One extra bit carries either the sign (signed mode) or a zero.
      ax  = {sgn_q & a_e[DataWidth-1], a_e};
      bx  = {sgn_q & b_e[DataWidth-1], b_e};
      prod_full = ax * bx;
      // Both modes' products fit exactly in 2*DataWidth bits.
      prod      = prod_full[2*DataWidth-1:0];
      prod_ext  = sgn_q ? AccWidth'($signed(prod)) : AccWidth'(prod);
      dot       = dot + prod_ext;
    end
  end

  // Held value of the element being computed, and last-element detect.
  always_comb begin
    cur  = res_q[(int'(row_q) * N + int'(col_q)) * AccWidth +: AccWidth];
    last = (row_q == RowW'(N - 1)) && (col_q == RowW'(N - 1));
  end

  // Job FSM: accept operands, sweep elements row-major, hold the result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the operand and result registers are wide but still reset,
      // because a following accumulate job must start from a zero result.
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      acc_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      case (state_q)
        IDLE: begin
          if (bus.in_valid_i) begin
            a_q     <= bus.operand_a_i;
            b_q     <= bus.operand_b_i;
            sgn_q   <= bus.signed_i;
            acc_q   <= bus.accumulate_i;
            row_q   <= '0;
            col_q   <= '0;
            state_q <= COMPUTE;
          end
        end
        COMPUTE: begin
          res_q[(int'(row_q) * N + int'(col_q)) * AccWidth +: AccWidth] <=
            (acc_q ? cur : '0) + dot;
          if (last) begin
            state_q <= DONE;
          end else if (col_q == RowW'(N - 1)) begin
            col_q <= '0;
            row_q <= row_q + RowW'(1);
          end else begin
            col_q <= col_q + RowW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready is forced low while reset is held even though the state is IDLE.
  assign bus.in_ready_o  = rst_ni && (state_q == IDLE);
  assign bus.out_valid_o = (state_q == DONE);
  assign bus.result_o    = res_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq (N=2, 8-bit elements, 17-bit results).
module tb_matmul_seq;

  localparam int N  = 2;
  localparam int W  = 8;
  localparam int AW = 17;

  typedef logic [N*N*W-1:0]  mat_t;
  typedef logic [N*N*AW-1:0] res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  matmul_seq_if #(.N(N), .DataWidth(W), .AccWidth(AW)) bus ();

  matmul_seq #(.N(N), .DataWidth(W), .AccWidth(AW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  function automatic mat_t pk(input logic [W-1:0] e00, e01, e10, e11);
    return {e11, e10, e01, e00};
  endfunction

  function automatic res_t pkc(input logic [AW-1:0] c00, c01, c10, c11);
    return {c11, c10, c01, c00};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One job: accept, scramble inputs, measure latency, check result,
  // optionally hold back-pressure with a competing request, then release.
  task automatic run_job(input string tag, input mat_t a, input mat_t b,
                         input logic sgn, input logic acc, input res_t exp,
                         input int hold);
    int cyc;
    @(negedge clk);
    check({tag, "_rdy"}, bus.in_ready_o, 1'b1);
    bus.operand_a_i  = a;
    bus.operand_b_i  = b;
    bus.signed_i     = sgn;
    bus.accumulate_i = acc;
    bus.in_valid_i   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid_i   = 1'b0;
    bus.operand_a_i  = $urandom;
    bus.operand_b_i  = $urandom;
    bus.signed_i     = ~sgn;
    bus.accumulate_i = ~acc;
    cyc = 0;
    @(negedge clk);
    while (!bus.out_valid_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, cyc, N * N);
    check({tag, "_res"}, bus.result_o, exp);
    check({tag, "_busy"}, bus.in_ready_o, 1'b0);
    if (hold > 0) begin
      bus.operand_a_i  = pk(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      bus.operand_b_i  = pk(8'hFF, 8'hFF, 8'hFF, 8'hFF);
      bus.accumulate_i = 1'b1;
      bus.in_valid_i   = 1'b1;
      repeat (hold) @(negedge clk);
      check({tag, "_hold_valid"}, bus.out_valid_o, 1'b1);
      check({tag, "_hold_rdy"}, bus.in_ready_o, 1'b0);
      check({tag, "_hold_res"}, bus.result_o, exp);
      bus.in_valid_i = 1'b0;
    end
    bus.out_ready_i = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready_i = 1'b0;
    @(negedge clk);
    check({tag, "_rel_valid"}, bus.out_valid_o, 1'b0);
    check({tag, "_rel_rdy"}, bus.in_ready_o, 1'b1);
    check({tag, "_idle_res"}, bus.result_o, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    mat_t a_basic, b_basic, a_max, a_neg, b_sgn;
    res_t c_basic;

    a_basic = pk(8'd1, 8'd2, 8'd3, 8'd4);
    b_basic = pk(8'd5, 8'd6, 8'd7, 8'd8);
    a_max   = pk(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    a_neg   = pk(8'hFF, 8'h00, 8'h00, 8'hFF);
    b_sgn   = pk(8'd2, 8'd3, 8'd4, 8'd5);
    c_basic = pkc(17'd19, 17'd22, 17'd43, 17'd50);

    rst_n            = 1'b0;
    bus.in_valid_i   = 1'b0;
    bus.signed_i     = 1'b0;
    bus.accumulate_i = 1'b0;
    bus.operand_a_i  = '0;
    bus.operand_b_i  = '0;
    bus.out_ready_i  = 1'b0;

    #12;
    check("rst_rdy", bus.in_ready_o, 1'b0);
    check("rst_valid", bus.out_valid_o, 1'b0);
    check("rst_res", bus.result_o, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_job("basic", a_basic, b_basic, 1'b0, 1'b0, c_basic, 0);
    run_job("accum", a_basic, b_basic, 1'b0, 1'b1,
            pkc(17'd38, 17'd44, 17'd86, 17'd100), 0);
    run_job("overwrite", a_basic, b_basic, 1'b0, 1'b0, c_basic, 0);
    run_job("signed", a_neg, b_sgn, 1'b1, 1'b0,
            pkc(17'h1FFFE, 17'h1FFFD, 17'h1FFFC, 17'h1FFFB), 0);
    run_job("umax", a_max, a_max, 1'b0, 1'b0,
            pkc(17'h1FC02, 17'h1FC02, 17'h1FC02, 17'h1FC02), 0);
    run_job("wrap", a_max, a_max, 1'b0, 1'b1,
            pkc(17'h1F804, 17'h1F804, 17'h1F804, 17'h1F804), 0);
    run_job("bp", a_basic, b_basic, 1'b0, 1'b0, c_basic, 10);

    // Reset while element idx=2 is being computed.
    @(negedge clk);
    bus.operand_a_i  = a_max;
    bus.operand_b_i  = a_max;
    bus.signed_i     = 1'b0;
    bus.accumulate_i = 1'b1;
    bus.in_valid_i   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_busy", bus.in_ready_o, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid_o, 1'b0);
    check("mid_rst_rdy", bus.in_ready_o, 1'b0);
    check("mid_rst_res", bus.result_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job("post_rst_acc", a_basic, b_basic, 1'b0, 1'b1, c_basic, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
